// File: rtl/register_file_32x32_if.sv
// ============================================================================
// register_file_32x32_if : read/write port bundle for the 32x32 register file
// Revision : 1.0
// ============================================================================
`default_nettype none

interface register_file_32x32_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] ADDR_R1;
   logic [ADDR_WIDTH-1:0] ADDR_R2;
   logic [ADDR_WIDTH-1:0] ADDR_W;
   logic [DATA_WIDTH-1:0] DATA_R1;
   logic [DATA_WIDTH-1:0] DATA_R2;
   logic [DATA_WIDTH-1:0] DATA_W;
   logic                  READ;
   logic                  WRITE;

   modport master (
      output ADDR_R1, ADDR_R2, ADDR_W, DATA_W, READ, WRITE,
      input  DATA_R1, DATA_R2
   );

   modport slave (
      input  ADDR_R1, ADDR_R2, ADDR_W, DATA_W, READ, WRITE,
      output DATA_R1, DATA_R2
   );
endinterface

`default_nettype wire

// File: rtl/register_file_32x32.sv
// ============================================================================
// register_file_32x32 : 32 x 32-bit register file, 2 gated combinational reads,
//                       1 synchronous write, synchronous active-high reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module register_file_32x32 #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  wire logic               CLK,
   input  wire logic               RST,
   register_file_32x32_if.slave    bus
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

   // Reset wins over a same-edge write; register 0 is an ordinary register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (bus.WRITE) begin
         mem_q[bus.ADDR_W] <= bus.DATA_W;
      end
   end

   // Reads see pre-edge contents only; DATA_W is never forwarded.
   assign bus.DATA_R1 = bus.READ ? mem_q[bus.ADDR_R1] : '0;
   assign bus.DATA_R2 = bus.READ ? mem_q[bus.ADDR_R2] : '0;

endmodule

`default_nettype wire

// File: tb/tb_register_file_32x32.sv
// ============================================================================
// tb_register_file_32x32 : directed stimulus with queue-based read scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_register_file_32x32;

   logic clk = 1'b0;
   logic rst;

   register_file_32x32_if bus ();

   register_file_32x32 dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] q_e1 [$];
   logic [31:0] q_e2 [$];
   string       q_nm [$];

   logic [31:0] ref_mem [32];

   // Monitor: every queued expectation is compared against the live outputs
   // at the falling edge, half a cycle after the inputs were driven.
   always @(negedge clk) begin
      while (q_e1.size() > 0) begin
         logic [31:0] e1, e2;
         string nm;
         e1 = q_e1.pop_front();
         e2 = q_e2.pop_front();
         nm = q_nm.pop_front();
         checks++;
         if (bus.DATA_R1 !== e1) begin
            errors++;
            $display("FAIL %s: DATA_R1 got %h expected %h", nm, bus.DATA_R1, e1);
         end
         checks++;
         if (bus.DATA_R2 !== e2) begin
            errors++;
            $display("FAIL %s: DATA_R2 got %h expected %h", nm, bus.DATA_R2, e2);
         end
      end
   end

   task automatic expect_rd(input string nm, input logic [31:0] e1, input logic [31:0] e2);
      q_nm.push_back(nm);
      q_e1.push_back(e1);
      q_e2.push_back(e2);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      bus.READ    = 1'b0;
      bus.WRITE   = 1'b0;
      bus.ADDR_R1 = '0;
      bus.ADDR_R2 = '0;
      bus.ADDR_W  = '0;
      bus.DATA_W  = '0;

      // Reset, then every address reads zero on both ports
      tick();
      rst = 1'b0;
      for (int a = 0; a < 32; a++) ref_mem[a] = 32'h0;
      bus.READ = 1'b1;
      for (int a = 0; a < 32; a++) begin
         bus.ADDR_R1 = 5'(a);
         bus.ADDR_R2 = 5'(31 - a);
         expect_rd("reset_clear", 32'h0, 32'h0);
         tick();
      end

      // Fill with i*10 while reads are gated off
      bus.READ  = 1'b0;
      bus.WRITE = 1'b1;
      for (int i = 0; i < 32; i++) begin
         bus.ADDR_W  = 5'(i);
         bus.DATA_W  = 32'(i * 10);
         bus.ADDR_R1 = 5'(i);
         bus.ADDR_R2 = 5'(i);
         expect_rd("fill_gated", 32'h0, 32'h0);
         tick();
         ref_mem[i] = 32'(i * 10);
      end
      bus.WRITE = 1'b0;

      bus.READ = 1'b1;
      for (int i = 0; i < 32; i++) begin
         bus.ADDR_R1 = 5'(i);
         bus.ADDR_R2 = 5'(i % 7);
         expect_rd("fill_read", 32'(i * 10), 32'((i % 7) * 10));
         tick();
      end
      bus.ADDR_R1 = 5'd31;
      bus.ADDR_R2 = 5'd3;
      expect_rd("fill_r31", 32'h136, 32'h1E);
      tick();

      // Read gating
      bus.READ    = 1'b0;
      bus.ADDR_R1 = 5'd31;
      bus.ADDR_R2 = 5'd6;
      expect_rd("gate_off", 32'h0, 32'h0);
      tick();
      bus.READ = 1'b1;
      expect_rd("gate_on", 32'd310, 32'd60);
      tick();

      // Same-address read/write: old value before the edge, new after
      bus.ADDR_W  = 5'd5;
      bus.ADDR_R1 = 5'd5;
      bus.ADDR_R2 = 5'd6;
      bus.DATA_W  = 32'hDEADBEEF;
      bus.WRITE   = 1'b1;
      expect_rd("same_addr_pre", 32'd50, 32'd60);
      tick();
      bus.WRITE = 1'b0;
      ref_mem[5] = 32'hDEADBEEF;
      expect_rd("same_addr_post", 32'hDEADBEEF, 32'd60);
      tick();

      // Concurrent read/write walk
      bus.WRITE  = 1'b1;
      bus.DATA_W = 32'd20;
      for (int i = 2; i <= 15; i++) begin
         bus.ADDR_W  = 5'(i + 1);
         bus.ADDR_R1 = 5'(i);
         bus.ADDR_R2 = 5'(2 * i);
         expect_rd("concurrent", ref_mem[i], ref_mem[2 * i]);
         tick();
         ref_mem[i + 1] = 32'd20;
      end
      bus.WRITE   = 1'b0;
      bus.ADDR_R1 = 5'd16;
      bus.ADDR_R2 = 5'd20;
      expect_rd("concurrent_tail", 32'd20, 32'd200);
      tick();

      // Reset beats a same-edge write
      rst         = 1'b1;
      bus.WRITE   = 1'b1;
      bus.ADDR_W  = 5'd7;
      bus.DATA_W  = 32'h1234;
      bus.ADDR_R1 = 5'd7;
      bus.ADDR_R2 = 5'd31;
      expect_rd("rst_prio_pre", 32'd20, 32'd310);
      tick();
      rst       = 1'b0;
      bus.WRITE = 1'b0;
      expect_rd("rst_prio_post", 32'h0, 32'h0);
      tick();
      for (int a = 0; a < 32; a += 5) begin
         bus.ADDR_R1 = 5'(a);
         bus.ADDR_R2 = 5'(a + 1);
         expect_rd("rst_mid_op", 32'h0, 32'h0);
         tick();
      end

      // Register 0 is writable; both ports on one address
      bus.WRITE  = 1'b1;
      bus.ADDR_W = 5'd0;
      bus.DATA_W = 32'hA5A5_5A5A;
      tick();
      bus.WRITE   = 1'b0;
      bus.ADDR_R1 = 5'd0;
      bus.ADDR_R2 = 5'd0;
      expect_rd("reg0_dual", 32'hA5A5_5A5A, 32'hA5A5_5A5A);
      tick();

      for (int n = 0; n < 10 && q_e1.size() > 0; n++) tick();
      if (q_e1.size() > 0) begin
         errors++;
         $display("FAIL drain: pending got %0d expected 0", q_e1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/register_file_32x32.md
Name: register_file_32x32

Overview:
- 32-entry x 32-bit general-purpose register file for the processor datapath.
- Two independent read ports (R1, R2) and one write port.
- Writes occur on the single clock; reads are combinational and gated by READ.
- Sits between instruction decode (addresses) and the ALU (operands) and writeback (DATA_W).

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of each address port.
- NUM_REGS, 32, number of registers (2**ADDR_WIDTH).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  synchronous reset, active-high.
- ADDR_R1  input  5  read port 1 address.
- ADDR_R2  input  5  read port 2 address.
- DATA_R1  output  32  read port 1 data.
- DATA_R2  output  32  read port 2 data.
- ADDR_W  input  5  write address.
- DATA_W  input  32  write data.
- READ  input  1  read enable for both read ports.
- WRITE  input  1  write enable.

Behaviour:
- One clock (CLK), reset synchronous and active-high (RST); no other clock or async input.
- Reset: on rising CLK with RST=1, all 32 registers are cleared to 32'h0. Reset has priority over WRITE in the same cycle.
- Write: on rising CLK with RST=0 and WRITE=1, mem[ADDR_W] <= DATA_W. With WRITE=0, no register changes.
- All 32 registers are writable, including register 0. There is no hardwired zero.
- Read: combinational.
  - READ=1: DATA_R1 = mem[ADDR_R1] and DATA_R2 = mem[ADDR_R2].
  - READ=0: both outputs are 32'h0.
  - No X/Z ever driven.
- Read ports are independent. R1 and R2 may address the same register and both return its value.
- Simultaneous READ=1 and WRITE=1 is legal.
  - Reads return the array contents before the edge (old value).
  - The written value becomes visible combinationally immediately after the rising edge that commits it.
  - No write-to-read bypass within the cycle.
- Reset mid-operation: after the reset edge, any READ returns 0 for all addresses until a new write.
- Addresses are exactly 5 bits. Wider drivers are truncated to bits [4:0] at the boundary.
- Outputs depend only on READ, the addresses and the array state; DATA_W is never forwarded.
- Latency:
  - Write-to-readable: 1 rising edge.
  - Address-to-data: combinational, 0 cycles.

Test Plan:
- Reset: assert RST=1 for one rising edge, then READ=1 on addresses 0..31 -> DATA_R1 = DATA_R2 = 0 for every address.
- Fill: for i=0..31 write DATA_W=i*10 to ADDR_W=i, one per cycle (WRITE=1, READ=0). Then READ=1 with ADDR_R1=i, ADDR_R2=i%7 -> DATA_R1=i*10 and DATA_R2=(i%7)*10 for all 32 i (e.g. i=31 -> 0x136 and 0x1E).
- Read-gating: after fill, READ=0 with any addresses -> DATA_R1 = DATA_R2 = 0. Set READ=1 -> values reappear without a clock edge.
- Concurrent read/write: after fill, for i=2..15 each cycle write DATA_W=20 to ADDR_W=i+1, with READ=1, ADDR_R1=i, ADDR_R2=2i.
  - DATA_R1=20 (written the previous cycle).
  - DATA_R2=2i*10 when 2i > i+1 and not yet rewritten (e.g. i=10 -> R2 reads reg 20 = 200).
- Same-address read/write: ADDR_R1=ADDR_W=5, DATA_W=32'hDEADBEEF, WRITE=1, READ=1 -> DATA_R1=50 before the edge and 32'hDEADBEEF after it.
- Reset priority: RST=1 and WRITE=1 (ADDR_W=7, DATA_W=32'h1234) on the same edge -> register 7 reads 0 afterwards.
